// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the default operand width.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the serial adder steps this single cell across the
// operand bits, one bit per clock.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor with valid/ready handshakes on both sides.
// Processes one bit per cycle, LSB first, through a single full-adder cell.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_INDEX = IW'(WIDTH - 1);

    state_t           state_reg;
    logic [IW-1:0]    index_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             overflow_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a   (a_reg[index_reg]),
        .b   (b_reg[index_reg]),
        .cin (carry_reg),
        .s   (fa_s),
        .co  (fa_co)
    );

    // Gated by rst_n so the upstream never sees a ready block while reset is held.
    assign in_ready  = rst_n && (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign overflow  = overflow_reg;
    assign busy      = busy_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            index_reg     <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            cout_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B, force carry-in high.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        index_reg <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[index_reg] <= fa_s;
                    carry_reg          <= fa_co;
                    if (index_reg == LAST_INDEX) begin
                        // carry_reg here is the carry into the MSB.
                        cout_reg      <= fa_co;
                        overflow_reg  <= carry_reg ^ fa_co;
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= DONE;
                    end else begin
                        index_reg <= index_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8) against an
// integer-arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        int ux, uy, sx, sy, ures, sres;
        logic [W-1:0] r;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            ures = ux - uy;
            sres = sx - sy;
            co   = (ux >= uy);
        end else begin
            ures = ux + uy + int'(c);
            sres = sx + sy + int'(c);
            co   = (ures > 255);
        end
        r  = ures[W-1:0];
        ov = (sres > 127) || (sres < -128);
        return {ov, co, r};
    endfunction

    task automatic randomize_operands();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    // One complete operation; hold = cycles out_ready is kept low in DONE.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic s, input int hold, input string name);
        logic [W+1:0] exp_v;
        logic [W+1:0] got;
        int lat;
        exp_v = model(x, y, c, s);
        a = x; b = y; cin = c; sub = s;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        randomize_operands();
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != W) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, W);
        end
        got = {overflow, cout, sum};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                     name, got[W+1], got[W], got[W-1:0], exp_v[W+1], exp_v[W], exp_v[W-1:0]);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || {overflow, cout, sum} !== got || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold cycle %0d: out_valid=%b in_ready=%b outs=%h want 1 0 %h",
                         name, i, out_valid, in_ready, {overflow, cout, sum}, got);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s return to idle: out_valid=%b in_ready=%b want 0 1",
                     name, out_valid, in_ready);
        end
        $display("op %s a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                 name, x, y, c, s, got[W-1:0], got[W], got[W+1], lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b ovf=%b want all 0",
                     in_ready, out_valid, busy, sum, cout, overflow);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready: got %b want 1", in_ready);
        end
        $display("reset done");
    endtask

    task automatic test_directed();
        do_op(8'd200, 8'd100, 1'b0, 1'b0, 0, "add_200_100");
        do_op(8'd127, 8'd1,   1'b0, 1'b0, 0, "add_ovf");
        do_op(8'd5,   8'd7,   1'b1, 1'b1, 0, "sub_5_7");
        do_op(8'hFF,  8'hFF,  1'b1, 1'b0, 0, "add_max_cin");
        do_op(8'h80,  8'h01,  1'b0, 1'b1, 0, "sub_ovf");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, "random");
        end
    endtask

    task automatic test_backpressure();
        logic [W+1:0] exp_v;
        logic [W+1:0] got;
        int lat;
        exp_v = model(8'd60, 8'd90, 1'b1, 1'b0);
        a = 8'd60; b = 8'd90; cin = 1'b1; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            lat++;
            if (i > 0) begin
                in_valid = 1'b1;
                a = 8'h11; b = 8'h22; sub = 1'b1;
                checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_run_ready: in_ready=%b busy=%b want 0 1", in_ready, busy);
                end
            end
        end
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        got = {overflow, cout, sum};
        checks++;
        if (lat != W || got !== exp_v) begin
            errors++;
            $display("FAIL bp_result: lat=%0d outs=%h want lat=%0d outs=%h", lat, got, W, exp_v);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || {overflow, cout, sum} !== got) begin
                errors++;
                $display("FAIL bp_hold %0d: out_valid=%b outs=%h want 1 %h",
                         i, out_valid, {overflow, cout, sum}, got);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_queue: busy=%b out_valid=%b want 0 0", busy, out_valid);
        end
        $display("backpressure done sum=%h", got[W-1:0]);
    endtask

    task automatic test_reset_midop();
        a = 8'hA5; b = 8'h3C; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: out_valid=%b sum=%h busy=%b in_ready=%b want 0 00 0 0",
                     out_valid, sum, busy, in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_release in_ready: got %b want 1", in_ready);
        end
        do_op(8'd1, 8'd1, 1'b0, 1'b0, 0, "after_reset_1p1");
    endtask

    task automatic test_back_to_back();
        int acc[$];
        logic [W+1:0] expq[$];
        logic [W+1:0] e;
        int results;
        logic took;
        results = 0;
        randomize_operands();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 40 && results < 2; i++) begin
            took = 1'b0;
            if (in_valid && in_ready === 1'b1) begin
                expq.push_back(model(a, b, cin, sub));
                acc.push_back(cyc + 1);
                took = 1'b1;
            end
            @(posedge clk); #1;
            if (took) begin
                randomize_operands();
                if (acc.size() == 2) in_valid = 1'b0;
            end
            if (out_valid === 1'b1 && expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if ({overflow, cout, sum} !== e) begin
                    errors++;
                    $display("FAIL b2b_result %0d: got %h want %h", results, {overflow, cout, sum}, e);
                end
                results++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (acc.size() != 2 || results != 2) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d results=%0d want 2 2", acc.size(), results);
        end else begin
            checks++;
            if (acc[1] - acc[0] != W + 2) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d want %0d", acc[1] - acc[0], W + 2);
            end
            $display("back_to_back accepts at %0d and %0d", acc[0], acc[1]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
